// File: rtl/reg32_wr_arb.sv
// Round-robin write-port arbiter plus zero-fill clear sequencer for the 16 x 32 register bank.
// All bank-facing outputs are registered: one write per cycle, grant latency one edge.
module reg32_wr_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              clr,
    output logic              gnt0,
    output logic              gnt1,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ptr_q, ptr_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;

    logic elig0, elig1, sel0, sel1;

    // A requester granted this cycle is masked so it cannot write twice while dropping req.
    assign elig0 = req0 & ~gnt0_q;
    assign elig1 = req1 & ~gnt1_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = 1'b0;
        sel0      = 1'b0;
        sel1      = 1'b0;

        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d   = CLEAR;
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = '0;
                    busy_d    = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end else begin
                    // ptr_q == 0 means requester 0 wins a tie.
                    sel0 = elig0 & (~elig1 | ~ptr_q);
                    sel1 = elig1 & ~sel0;
                    if (sel0) begin
                        gnt0_d    = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr0;
                        wr_data_d = wdata0;
                        ptr_d     = 1'b1;
                    end else if (sel1) begin
                        gnt1_d    = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr1;
                        wr_data_d = wdata1;
                        ptr_d     = 1'b0;
                    end
                end
            end
            CLEAR: begin
                // Counter wraps to zero once the last location is issued; that ends the sweep.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = '0;
                    busy_d    = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_reg32_wr_arb.sv
// Scoreboard bench for reg32_wr_arb: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_reg32_wr_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, clr = 1'b0;
    logic [3:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, wr_en, busy;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;

    reg32_wr_arb #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1),
        .clr(clr),
        .gnt0(gnt0), .gnt1(gnt1), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        bsy;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Inputs change 1 time unit after a negedge, so the next posedge samples them.
    task automatic drv(input logic c, input logic r0, input logic [3:0] a0, input logic [31:0] d0,
                       input logic r1, input logic [3:0] a1, input logic [31:0] d1);
        @(negedge clk);
        #1;
        clr = c; req0 = r0; addr0 = a0; wdata0 = d0;
        req1 = r1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic expect_out(input string tag, input logic g0, input logic g1, input logic we,
                              input logic [3:0] a, input logic [31:0] d, input logic b);
        exp_t e;
        e.g0 = g0; e.g1 = g1; e.we = we; e.addr = a; e.data = d; e.bsy = b;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Monitor: each negedge after the sampled posedge, compare against the oldest expectation.
    always @(negedge clk) begin
        exp_t  e;
        string t;
        logic  ok;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            t  = tag_q.pop_front();
            ok = (gnt0 === e.g0) && (gnt1 === e.g1) && (wr_en === e.we) && (busy === e.bsy) &&
                 (!e.we || ((wr_addr === e.addr) && (wr_data === e.data)));
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL %s: got g0=%b g1=%b we=%b a=%h d=%h busy=%b want g0=%b g1=%b we=%b a=%h d=%h busy=%b",
                         t, gnt0, gnt1, wr_en, wr_addr, wr_data, busy,
                         e.g0, e.g1, e.we, e.addr, e.data, e.bsy);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_gnt0", 32'(gnt0), 32'h0);
        chk("rst_gnt1", 32'(gnt1), 32'h0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        #10;
        reset = 1'b0;

        // Sweep interrupted by reset at address 7
        for (int i = 0; i < 8; i++) begin
            drv(i == 0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
            expect_out("rst_sweep", 1'b0, 1'b0, 1'b1, 4'(i), 32'h0, 1'b1);
        end
        @(negedge clk);
        #1;
        chk("pre_rst_addr7", 32'(wr_addr), 32'h7);
        reset = 1'b1;
        #1;
        chk("async_wr_en", 32'(wr_en), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_gnt0", 32'(gnt0), 32'h0);
        chk("async_gnt1", 32'(gnt1), 32'h0);
        chk("async_wr_addr", 32'(wr_addr), 32'h0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
            expect_out("post_rst_idle", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        end

        // Contention: alternating grants starting with requester 0
        for (int i = 0; i < 6; i++) begin
            drv(1'b0, 1'b1, 4'h3, 32'hA, 1'b1, 4'h5, 32'hB);
            if (i % 2 == 0) expect_out("contend_g0", 1'b1, 1'b0, 1'b1, 4'h3, 32'hA, 1'b0);
            else            expect_out("contend_g1", 1'b0, 1'b1, 1'b1, 4'h5, 32'hB, 1'b0);
        end
        drv(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        expect_out("contend_end", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);

        // Single write
        drv(1'b0, 1'b1, 4'h2, 32'h1, 1'b0, 4'h0, 32'h0);
        expect_out("single_gnt", 1'b1, 1'b0, 1'b1, 4'h2, 32'h1, 1'b0);
        drv(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        expect_out("single_drop", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);

        // Solo back-to-back on requester 1: every other cycle
        for (int i = 0; i < 6; i++) begin
            drv(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'hC, 32'hC0DE);
            if (i % 2 == 0) expect_out("solo_gnt", 1'b0, 1'b1, 1'b1, 4'hC, 32'hC0DE, 1'b0);
            else            expect_out("solo_mask", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        end
        drv(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        expect_out("solo_end", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);

        // Clear beats a simultaneous request; request is served at E+17
        for (int i = 0; i < 16; i++) begin
            drv(i == 0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h9, 32'hFFFF_0000);
            expect_out("clr_req_sweep", 1'b0, 1'b0, 1'b1, 4'(i), 32'h0, 1'b1);
        end
        drv(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h9, 32'hFFFF_0000);
        expect_out("clr_req_e16", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        drv(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h9, 32'hFFFF_0000);
        expect_out("clr_req_e17_gnt1", 1'b0, 1'b1, 1'b1, 4'h9, 32'hFFFF_0000, 1'b0);
        drv(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        expect_out("clr_req_end", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);

        // clr re-asserted mid-sweep is ignored
        for (int i = 0; i < 16; i++) begin
            drv((i == 0) || (i == 5), 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
            expect_out("reclr_sweep", 1'b0, 1'b0, 1'b1, 4'(i), 32'h0, 1'b1);
        end
        drv(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        expect_out("reclr_e16", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        drv(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        expect_out("reclr_e17", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
